clk_monitor: RTL and testbench

CLK_MONITOR -- requirements
Module: clk_monitor

---
 rtl/clk_monitor.sv | 159 +++++++++++++++
 tb/tb_clk_monitor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Clock monitor: measures half-periods of an asynchronous divided clock in clk_in cycles,
// qualifies lock after consecutive in-tolerance intervals and flags short, long and
// timeout faults in a sticky register.
module clk_monitor #(
  parameter int unsigned TOGGLE_VALUE = 1000000,
  parameter int unsigned TOL          = 16,
  parameter int unsigned LOCK_COUNT   = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic        clear_fault,
  output logic [25:0] half_period,
  output logic        period_valid,
  output logic        locked,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned Exp        = TOGGLE_VALUE + 1;
  localparam logic [25:0] MinOk      = 26'(Exp - TOL);
  localparam logic [25:0] MaxOk      = 26'(Exp + TOL);
  localparam logic [25:0] TimeoutCnt = 26'(2 * Exp - 1);
  localparam int unsigned GoodW      = $clog2(LOCK_COUNT + 1);
  localparam logic [GoodW-1:0] GoodMax = GoodW'(LOCK_COUNT);

  localparam logic [1:0] CodeNone    = 2'b00;
  localparam logic [1:0] CodeShort   = 2'b01;
  localparam logic [1:0] CodeLong    = 2'b10;
  localparam logic [1:0] CodeTimeout = 2'b11;

  typedef enum logic [1:0] {StIdle, StArmed, StTrack} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, hist_q;
  logic [25:0]       cnt_q, cnt_d;
  logic              hold_q, hold_d;
  logic [25:0]       half_period_q, half_period_d;
  logic              period_valid_q, period_valid_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [GoodW-1:0]  good_q, good_d;

  logic              edge_det;
  logic              measure;
  logic              timeout;
  logic [25:0]       meas;

  assign edge_det = sync2_q ^ hist_q;
  assign meas     = cnt_q + 26'd1;

  // State register plus all datapath flops; async active-low reset.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      hist_q         <= 1'b0;
      cnt_q          <= '0;
      hold_q         <= 1'b0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= CodeNone;
      good_q         <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= slow_clk;
      sync2_q        <= sync1_q;
      hist_q         <= sync2_q;
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
      good_q         <= good_d;
    end
  end

  // Next-state logic: first edge only arms, later edges measure, timeout drops to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (edge_det) state_d = StArmed;
      StArmed: begin
        if (edge_det)     state_d = StTrack;
        else if (timeout) state_d = StIdle;
      end
      StTrack: if (timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: measurement strobe and timeout detect.
  always_comb begin
    measure = edge_det && (state_q != StIdle);
    timeout = !edge_det && (state_q != StIdle) && (cnt_q >= TimeoutCnt);
  end

  // Interval counter: clears on edge, freezes after a timeout, saturates while idle.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (edge_det) begin
      cnt_d  = '0;
      hold_d = 1'b0;
    end else if (timeout) begin
      hold_d = 1'b1;
    end else if (!hold_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 26'd1;
    end
  end

  // Measurement capture, tolerance check, lock qualification and sticky fault.
  always_comb begin
    half_period_d  = half_period_q;
    period_valid_d = 1'b0;
    good_d         = good_q;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;
    // Clear is applied first so a fault in the same cycle overrides it.
    if (clear_fault) begin
      fault_d      = 1'b0;
      fault_code_d = CodeNone;
    end
    if (measure) begin
      half_period_d  = meas;
      period_valid_d = 1'b1;
      if (meas < MinOk) begin
        fault_d      = 1'b1;
        fault_code_d = CodeShort;
        good_d       = '0;
      end else if (meas > MaxOk) begin
        fault_d      = 1'b1;
        fault_code_d = CodeLong;
        good_d       = '0;
      end else if (good_q != GoodMax) begin
        good_d = good_q + 1'b1;
      end
    end
    if (timeout) begin
      fault_d      = 1'b1;
      fault_code_d = CodeTimeout;
      good_d       = '0;
    end
    locked_d = (good_d == GoodMax);
  end

  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor with EXP=10, TOL=1, LOCK_COUNT=4.
module tb_clk_monitor;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        slow_clk = 1'b0;
  logic        clear_fault = 1'b0;
  logic [25:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        fault;
  logic [1:0]  fault_code;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          gap;
    logic        pv;
    logic [25:0] hp;
    logic        lk;
    logic        flt;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[13];

  clk_monitor #(
    .TOGGLE_VALUE(9),
    .TOL(1),
    .LOCK_COUNT(4)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .slow_clk(slow_clk),
    .clear_fault(clear_fault),
    .half_period(half_period),
    .period_valid(period_valid),
    .locked(locked),
    .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic pv, input logic [25:0] hp,
                          input logic lk, input logic flt, input logic [1:0] code);
    chk({tag, "_pv"},   32'(period_valid), 32'(pv));
    chk({tag, "_hp"},   32'(half_period),  32'(hp));
    chk({tag, "_lk"},   32'(locked),       32'(lk));
    chk({tag, "_flt"},  32'(fault),        32'(flt));
    chk({tag, "_code"}, 32'(fault_code),   32'(code));
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    // gap = cycles until the next toggle; expected values are sampled 3 cycles after toggle.
    vecs[0]  = '{10, 1'b0, 26'd0,  1'b0, 1'b0, 2'd0};
    vecs[1]  = '{10, 1'b1, 26'd10, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{10, 1'b1, 26'd10, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{10, 1'b1, 26'd10, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{9,  1'b1, 26'd10, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{11, 1'b1, 26'd9,  1'b1, 1'b0, 2'd0};
    vecs[6]  = '{8,  1'b1, 26'd11, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{12, 1'b1, 26'd8,  1'b0, 1'b1, 2'd1};
    vecs[8]  = '{10, 1'b1, 26'd12, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{10, 1'b1, 26'd10, 1'b0, 1'b1, 2'd2};
    vecs[10] = '{10, 1'b1, 26'd10, 1'b0, 1'b1, 2'd2};
    vecs[11] = '{10, 1'b1, 26'd10, 1'b0, 1'b1, 2'd2};
    vecs[12] = '{4,  1'b1, 26'd10, 1'b1, 1'b1, 2'd2};

    #1 rst = 1'b0;
    #1 chk_outs("reset", 1'b0, 26'd0, 1'b0, 1'b0, 2'd0);
    negs(2);
    rst = 1'b1;
    negs(3);

    // Nominal lock, tolerance boundaries, short/long faults, relock.
    for (int i = 0; i < 13; i++) begin
      slow_clk = ~slow_clk;
      negs(2);
      chk($sformatf("v%0d_early_pv", i), 32'(period_valid), 32'd0);
      negs(1);
      chk_outs($sformatf("v%0d", i), vecs[i].pv, vecs[i].hp, vecs[i].lk, vecs[i].flt,
               vecs[i].code);
      negs(1);
      chk($sformatf("v%0d_late_pv", i), 32'(period_valid), 32'd0);
      if (vecs[i].gap > 4) negs(vecs[i].gap - 4);
    end

    // Timeout: last edge at negedge 0, cnt reaches 19 so fault shows at negedge 23.
    negs(18);
    chk_outs("pre_timeout", 1'b0, 26'd10, 1'b1, 1'b1, 2'd2);
    negs(1);
    chk_outs("timeout", 1'b0, 26'd10, 1'b0, 1'b1, 2'd3);

    // From idle: first edge arms only, second edge measures without a new fault.
    negs(2);
    slow_clk = ~slow_clk;
    negs(3);
    chk_outs("idle_arm", 1'b0, 26'd10, 1'b0, 1'b1, 2'd3);
    negs(7);
    slow_clk = ~slow_clk;
    negs(3);
    chk_outs("after_to", 1'b1, 26'd10, 1'b0, 1'b1, 2'd3);

    // Clear colliding with a short fault: the fault wins, then a lone clear takes effect.
    negs(2);
    slow_clk = ~slow_clk;
    negs(2);
    clear_fault = 1'b1;
    negs(1);
    chk_outs("collide", 1'b1, 26'd5, 1'b0, 1'b1, 2'd1);
    negs(1);
    chk_outs("cleared", 1'b0, 26'd5, 1'b0, 1'b0, 2'd0);
    clear_fault = 1'b0;
    negs(1);
    slow_clk = ~slow_clk;
    negs(3);
    chk_outs("short2", 1'b1, 26'd5, 1'b0, 1'b1, 2'd1);

    // Mid-operation asynchronous reset clears outputs without a clock edge.
    #2 rst = 1'b0;
    #1 chk_outs("mid_reset", 1'b0, 26'd0, 1'b0, 1'b0, 2'd0);
    slow_clk = 1'b0;
    negs(2);
    rst = 1'b1;
    negs(3);
    slow_clk = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      negs(1);
      chk($sformatf("post_rst_nopv%0d", k), 32'(period_valid), 32'd0);
    end
    slow_clk = 1'b0;
    negs(3);
    chk_outs("post_rst", 1'b1, 26'd10, 1'b0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
